mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, address width.
REQ-002 Parameter DATA_W, default 16, data width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk only.
REQ-005 ld_req  input  1  loader request; held until ld_ack.
REQ-006 ld_addr  input  ADDR_W  loader write address.
REQ-007 ld_wdata  input  DATA_W  loader write data.
REQ-008 ld_ack  output  1  one-cycle loader completion pulse.
REQ-009 cpu_req  input  1  CPU request; held until cpu_ack.
REQ-010 cpu_we  input  1  1 = CPU write, 0 = CPU read.
REQ-011 cpu_addr  input  ADDR_W  CPU address.
REQ-012 cpu_wdata  input  DATA_W  CPU write data.
REQ-013 cpu_rdata  output  DATA_W  CPU read data; valid when cpu_ack is high, then held.
REQ-014 cpu_ack  output  1  one-cycle CPU completion pulse.
REQ-015 mem_addr  output  ADDR_W  registered memory address.
REQ-016 mem_din  output  DATA_W  registered memory write data.
REQ-017 mem_rd  output  1  memory read strobe.
REQ-018 mem_we  output  1  memory write strobe.
REQ-019 mem_dout  input  DATA_W  memory read data; valid with mem_complete.
REQ-020 mem_complete  input  1  memory completion; any latency of 1 or more cycles.

Function
REQ-021 FSM states: IDLE, BUSY_LD, BUSY_CPU, DONE.
- IDLE -> BUSY_x on grant.
- BUSY_x -> DONE on mem_complete.
- DONE -> IDLE unconditionally.
REQ-022 Grant and latch:
- Grant is evaluated only in IDLE.
- At grant, addr, wdata and we of the winner are latched into mem_addr/mem_din.
- Strobe asserts on the next cycle: request seen at edge N gives a strobe during cycle N+1.
REQ-023 Strobes:
- Exactly one of mem_rd/mem_we is high, and only in BUSY_x; it stays high until mem_complete is sampled.
- Loader grants always drive mem_we.
- mem_addr/mem_din stay stable for the whole BUSY_x state.
REQ-024 Completion:
- mem_complete sampled high in BUSY_x at edge M: strobes are low, the matching ack is high and state is DONE during cycle M+1.
- On a CPU read, cpu_rdata captures mem_dout at edge M.
REQ-025 The DONE cycle forces a one-cycle gap so that a requester still holding req at ack is not re-granted; minimum throughput is one access per (memory latency + 2) cycles.
REQ-026 Simultaneous ld_req and cpu_req in IDLE: the loader wins (fixed priority) unless REQ-031 applies.
REQ-027 A req dropped before its ack does not abort the access: the access completes and the ack still pulses.
REQ-028 mem_complete in IDLE or DONE is ignored, with no ack and no state change.
REQ-029 cpu_rdata changes only on a CPU read completion.

Reset
REQ-030 reset low at a rising edge:
- state goes to IDLE.
- ld_ack, cpu_ack, mem_rd, mem_we, mem_addr, mem_din and cpu_rdata go to 0.
- An in-flight access is abandoned with no ack.
- The round-robin pointer goes to "last = CPU".

Configuration
REQ-031 With macro MEM_ARB_ROUND_ROBIN_EN defined:
- Simultaneous requests alternate grant; the requester not granted last wins.
- The pointer updates at each grant, and a lone requester is always granted.
- Without the macro: fixed loader priority, and no pointer register exists.

Structure
REQ-032 Package lc3_mem_pkg holds the state enum, ADDR_W/DATA_W defaults and requester ID constants (REQ_LD=0, REQ_CPU=1).
REQ-033 The block is a single module with no sub-module; grant logic is inline.

Verification
REQ-034 Loader write:
- ld_req, addr 0x3000, data 0x1234, memory latency 3.
- Response: mem_we high for 3 cycles with mem_addr=0x3000, mem_din=0x1234, then ld_ack pulses once.
REQ-035 CPU read:
- cpu_req with cpu_we=0, addr 0x3000, mem_dout=0x1234 at complete.
- Response: mem_rd high, cpu_ack one cycle, cpu_rdata=0x1234 and held afterwards.
REQ-036 Contention:
- ld_req and cpu_req raised in the same cycle, both held.
- Without macro: loader served first, then CPU after the DONE gap.
- With macro: loader first, then CPU, and on the next contention the loader wins again.
REQ-037 Reset during access:
- reset low while mem_rd is high.
- Response: next cycle all outputs 0, state IDLE, no ack; a later mem_complete is ignored.
REQ-038 Early drop and stray complete:
- cpu_req deasserted mid-access: cpu_ack still pulses.
- mem_complete pulsed in IDLE: no ack and no strobe.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// ---------------------------------------------------------------------------
// lc3_mem_pkg
// Shared definitions for the LC-3 memory arbiter:
//   - default address / data widths
//   - arbiter FSM state encoding
//   - requester IDs used by the round-robin pointer
// ---------------------------------------------------------------------------
package lc3_mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // Arbiter FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_BUSY_LD  = 2'd1;
    localparam state_t ST_BUSY_CPU = 2'd2;
    localparam state_t ST_DONE     = 2'd3;

    // Requester IDs
    localparam logic REQ_LD  = 1'b0;
    localparam logic REQ_CPU = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Two-requester (program loader, CPU) arbiter in front of a single memory
// port with variable completion latency. One access is in flight at a time.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate the grant
// between simultaneous requesters. Without it the loader has fixed priority.
//
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   ld_req/ld_addr/ld_wdata/ld_ack
//                     loader write channel, req held until ack pulse
//   cpu_req/cpu_we/cpu_addr/cpu_wdata/cpu_rdata/cpu_ack
//                     CPU read/write channel, req held until ack pulse
//   mem_addr/mem_din/mem_rd/mem_we
//                     registered memory command
//   mem_dout/mem_complete
//                     memory response (read data valid with complete)
// ---------------------------------------------------------------------------
module mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_rd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_complete
);

    state_t state;
    logic   grant_ld;
    logic   grant_cpu;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remembers which requester was granted most recently; on contention
    // the other one wins.
    logic last_grant;

    always_comb begin
        grant_ld  = 1'b0;
        grant_cpu = 1'b0;
        if (ld_req && cpu_req) begin
            if (last_grant == REQ_CPU) begin
                grant_ld = 1'b1;
            end else begin
                grant_cpu = 1'b1;
            end
        end else begin
            grant_ld  = ld_req;
            grant_cpu = cpu_req;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= REQ_CPU;
        end else if (state == ST_IDLE) begin
            if (grant_ld) begin
                last_grant <= REQ_LD;
            end else if (grant_cpu) begin
                last_grant <= REQ_CPU;
            end
        end
    end
`else
    always_comb begin
        grant_ld  = ld_req;
        grant_cpu = cpu_req & ~ld_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            ld_ack    <= 1'b0;
            cpu_ack   <= 1'b0;
            mem_rd    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            cpu_rdata <= '0;
        end else begin
            // Acks are single-cycle pulses; only the completion branch sets them.
            ld_ack  <= 1'b0;
            cpu_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_ld) begin
                        mem_addr <= ld_addr;
                        mem_din  <= ld_wdata;
                        mem_we   <= 1'b1;
                        mem_rd   <= 1'b0;
                        state    <= ST_BUSY_LD;
                    end else if (grant_cpu) begin
                        mem_addr <= cpu_addr;
                        mem_din  <= cpu_wdata;
                        mem_we   <= cpu_we;
                        mem_rd   <= ~cpu_we;
                        state    <= ST_BUSY_CPU;
                    end
                end
                ST_BUSY_LD: begin
                    if (mem_complete) begin
                        mem_we <= 1'b0;
                        mem_rd <= 1'b0;
                        ld_ack <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_BUSY_CPU: begin
                    if (mem_complete) begin
                        if (mem_rd) begin
                            cpu_rdata <= mem_dout;
                        end
                        mem_we  <= 1'b0;
                        mem_rd  <= 1'b0;
                        cpu_ack <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                // DONE: one dead cycle so a requester still holding req while
                // its ack is high cannot be granted again.
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              ld_req = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_wdata = '0;
    logic              ld_ack;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_rd;
    logic              mem_we;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_complete;

    logic              resp_cpl = 1'b0;
    logic              stray_cpl = 1'b0;
    assign mem_complete = resp_cpl | stray_cpl;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_we(mem_we),
        .mem_dout(mem_dout), .mem_complete(mem_complete)
    );

    typedef struct {
        logic        is_ld;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;   // write data, or read data expected on cpu_rdata
        int          lat;
    } item_t;

    item_t exp_q[$];
    item_t pend;
    logic  pend_valid = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int ld_ack_cnt = 0;
    int cpu_ack_cnt = 0;

    int          lat = 3;
    logic        mem_auto = 1'b1;
    logic [15:0] rd_val = 16'h0000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: completes an access after `lat` strobe cycles; read data
    // is only meaningful in the completion cycle.
    initial begin : responder
        int cnt;
        cnt = 0;
        mem_dout = 16'hDEAD;
        forever begin
            @(posedge clk); #1;
            resp_cpl = 1'b0;
            mem_dout = 16'hDEAD;
            if ((mem_rd || mem_we) && mem_auto) begin
                cnt++;
                if (cnt >= lat) begin
                    resp_cpl = 1'b1;
                    mem_dout = rd_val;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Output monitor: pops the scoreboard at each new strobe and checks the
    // access through to its ack.
    logic prev_strb = 1'b0;
    logic strb;
    int   strb_cycles = 0;
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (ld_ack)  ld_ack_cnt++;
            if (cpu_ack) cpu_ack_cnt++;
            if (!reset) begin
                pend_valid  = 1'b0;
                prev_strb   = 1'b0;
                strb_cycles = 0;
                continue;
            end
            strb = mem_rd | mem_we;
            if (strb && !prev_strb) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_strobe", 32'(strb), 32'(1'b0));
                end else begin
                    pend        = exp_q.pop_front();
                    pend_valid  = 1'b1;
                    strb_cycles = 0;
                end
            end
            if (strb && pend_valid) begin
                strb_cycles++;
                check_eq("mem_addr", 32'(mem_addr), 32'(pend.addr));
                if (pend.we) check_eq("mem_din", 32'(mem_din), 32'(pend.data));
                check_eq("strobe_kind", 32'({mem_rd, mem_we}), 32'({~pend.we, pend.we}));
                check_eq("ack_in_busy", 32'({ld_ack, cpu_ack}), 32'(2'b00));
            end else if (!strb && prev_strb && pend_valid) begin
                check_eq("strobe_cycles", 32'(strb_cycles), 32'(pend.lat));
                check_eq("ack_sel", 32'({ld_ack, cpu_ack}), 32'(pend.is_ld ? 2'b10 : 2'b01));
                if (!pend.is_ld && !pend.we) check_eq("cpu_rdata_ack", 32'(cpu_rdata), 32'(pend.data));
                pend_valid = 1'b0;
            end else if (ld_ack || cpu_ack) begin
                check_eq("stray_ack", 32'({ld_ack, cpu_ack}), 32'(2'b00));
            end
            prev_strb = strb;
        end
    end

    task automatic push_item(input logic is_ld, input logic we, input logic [15:0] addr,
                             input logic [15:0] data, input int l);
        item_t it;
        it.is_ld = is_ld; it.we = we; it.addr = addr; it.data = data; it.lat = l;
        exp_q.push_back(it);
    endtask

    task automatic raise_ld(input logic [15:0] addr, input logic [15:0] data);
        ld_req = 1'b1; ld_addr = addr; ld_wdata = data;
        push_item(1'b1, 1'b1, addr, data, lat);
    endtask

    task automatic raise_cpu(input logic we, input logic [15:0] addr, input logic [15:0] data);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr;
        cpu_wdata = we ? data : 16'hBEEF;
        if (!we) rd_val = data;
        push_item(1'b0, we, addr, data, lat);
    endtask

    // Holds requests until one edge after their ack was seen, so a missing
    // DONE gap would show up as an extra grant.
    task automatic drain(input int budget);
        int  n;
        logic drop_ld, drop_cpu;
        n = 0;
        while ((exp_q.size() != 0 || pend_valid) && n < budget) begin
            @(negedge clk);
            drop_ld  = ld_ack;
            drop_cpu = cpu_ack;
            @(posedge clk); #1;
            if (drop_ld)  ld_req  = 1'b0;
            if (drop_cpu) cpu_req = 1'b0;
            n++;
        end
        if (n >= budget) check_eq("drain_timeout", 32'(n), 32'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic idle_quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_eq(tag, 32'({ld_ack, cpu_ack, mem_rd, mem_we}), 32'(4'b0000));
        end
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int ld0, cpu0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ctrl", 32'({ld_ack, cpu_ack, mem_rd, mem_we}), 32'(4'b0000));
        check_eq("rst_mem_addr", 32'(mem_addr), 32'(0));
        check_eq("rst_mem_din", 32'(mem_din), 32'(0));
        check_eq("rst_cpu_rdata", 32'(cpu_rdata), 32'(0));
        reset = 1'b1;
        @(posedge clk); #1;

        // Loader write, latency 3
        lat = 3;
        raise_ld(16'h3000, 16'h1234);
        @(posedge clk); #1;
        check_eq("grant_latency", 32'(mem_we), 32'(1'b1));
        drain(100);
        check_eq("ld_ack_count", 32'(ld_ack_cnt), 32'(1));

        // CPU read, latency 2
        lat = 2;
        raise_cpu(1'b0, 16'h3000, 16'h1234);
        drain(100);
        check_eq("cpu_ack_count", 32'(cpu_ack_cnt), 32'(1));
        idle_quiet("idle_after_read", 2);
        check_eq("rdata_hold", 32'(cpu_rdata), 32'(16'h1234));

        // CPU write, latency 1: read data register must not move
        lat = 1;
        raise_cpu(1'b1, 16'h4001, 16'h55AA);
        drain(100);
        check_eq("rdata_after_write", 32'(cpu_rdata), 32'(16'h1234));

        // Contention twice after a CPU grant: loader first each time
        lat = 2;
        for (int k = 0; k < 2; k++) begin
            ld_req = 1'b1; ld_addr = 16'h5000 + 16'(k); ld_wdata = 16'hA5A0 + 16'(k);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h6000 + 16'(k);
            cpu_wdata = 16'hBEEF; rd_val = 16'h0F00 + 16'(k);
            push_item(1'b1, 1'b1, 16'h5000 + 16'(k), 16'hA5A0 + 16'(k), lat);
            push_item(1'b0, 1'b0, 16'h6000 + 16'(k), 16'h0F00 + 16'(k), lat);
            drain(200);
        end
        check_eq("rdata_contention", 32'(cpu_rdata), 32'(16'h0F01));

        // Lone loader grant, then contention: order depends on the build
        raise_ld(16'h7000, 16'h1111);
        drain(100);
        ld_req = 1'b1; ld_addr = 16'h7001; ld_wdata = 16'h2222;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h7002; cpu_wdata = 16'h3333;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        push_item(1'b0, 1'b1, 16'h7002, 16'h3333, lat);
        push_item(1'b1, 1'b1, 16'h7001, 16'h2222, lat);
`else
        push_item(1'b1, 1'b1, 16'h7001, 16'h2222, lat);
        push_item(1'b0, 1'b1, 16'h7002, 16'h3333, lat);
`endif
        drain(200);

        // Early drop of cpu_req: access still completes and acks
        cpu0 = cpu_ack_cnt;
        lat = 4;
        raise_cpu(1'b0, 16'h3100, 16'h7777);
        repeat (2) @(posedge clk);
        #1;
        cpu_req = 1'b0;
        drain(100);
        check_eq("early_drop_ack", 32'(cpu_ack_cnt - cpu0), 32'(1));
        check_eq("early_drop_rdata", 32'(cpu_rdata), 32'(16'h7777));

        // Stray completion in IDLE
        ld0 = ld_ack_cnt; cpu0 = cpu_ack_cnt;
        stray_cpl = 1'b1;
        @(posedge clk); #1;
        stray_cpl = 1'b0;
        idle_quiet("stray_idle", 3);
        check_eq("stray_idle_acks", 32'((ld_ack_cnt - ld0) + (cpu_ack_cnt - cpu0)), 32'(0));
        check_eq("stray_idle_rdata", 32'(cpu_rdata), 32'(16'h7777));

        // Reset in the middle of a read
        mem_auto = 1'b0;
        raise_cpu(1'b0, 16'h3200, 16'h9999);
        n = 0;
        while (!mem_rd && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("rd_before_reset", 32'(mem_rd), 32'(1'b1));
        repeat (2) @(posedge clk);
        #1;
        ld0 = ld_ack_cnt; cpu0 = cpu_ack_cnt;
        reset = 1'b0;
        cpu_req = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check_eq("rst_mid_ctrl", 32'({ld_ack, cpu_ack, mem_rd, mem_we}), 32'(4'b0000));
        check_eq("rst_mid_addr", 32'(mem_addr), 32'(0));
        check_eq("rst_mid_din", 32'(mem_din), 32'(0));
        check_eq("rst_mid_rdata", 32'(cpu_rdata), 32'(0));
        reset = 1'b1;
        mem_auto = 1'b1;
        @(posedge clk); #1;
        stray_cpl = 1'b1;
        @(posedge clk); #1;
        stray_cpl = 1'b0;
        idle_quiet("post_reset_quiet", 3);
        check_eq("post_reset_acks", 32'((ld_ack_cnt - ld0) + (cpu_ack_cnt - cpu0)), 32'(0));

        // Normal operation resumes after reset
        lat = 2;
        raise_cpu(1'b0, 16'h3300, 16'hC0DE);
        drain(100);
        check_eq("resume_rdata", 32'(cpu_rdata), 32'(16'hC0DE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
